op_issuer: RTL and testbench

Command sequencer that drives the matrix controller's `operation` / `in_data` inputs. It buffers host commands in a small FIFO and expands each one into a correctly timed stream:
- matmul (opcode 1) is held for the full memory-shift window, then followed by idle cycles;
- serial page write (opcode 2) is paced word-by-word from a host data stream.

It sits between the host/DMA side and the controller, which it instantiates nowhere; it only drives its inputs.

---
 rtl/op_issuer.sv | 148 ++++++++++++++
 tb/tb_op_issuer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_issuer.sv
// Command sequencer for the matrix controller: buffers host commands in a FIFO and
// expands each into a timed operation/in_data stream (held matmul, paced page write).
module op_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int MM_HOLD    = 64,
  parameter int MM_DRAIN   = 16,
  parameter int WR_LEN     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_word,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic [31:0] data_word,
  output logic [31:0] operation,
  output logic [31:0] in_data,
  output logic        busy,
  output logic        err
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMX0 = (MM_HOLD > MM_DRAIN) ? MM_HOLD : MM_DRAIN;
  localparam int CMAX = (CMX0 > WR_LEN) ? CMX0 : WR_LEN;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MM  = 4'd1;
  localparam logic [3:0] OP_WR  = 4'd2;

  typedef struct packed {
    logic [11:0] rsvd;
    logic [3:0]  d;
    logic [3:0]  c;
    logic [3:0]  b;
    logic [3:0]  a;
    logic [3:0]  opcode;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MM_RUN,
    S_MM_DRN,
    S_WR_RUN,
    S_GAP
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  cmd_t           cur;

  cmd_t           mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           full, empty, push, pop, data_hs;
  cmd_t           head;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign cmd_ready  = reset && enable && !full;
  assign data_ready = reset && enable && (state == S_WR_RUN);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = reset && enable && (state == S_IDLE) && !empty;
  assign data_hs    = data_valid && data_ready;
  assign busy       = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= cmd_t'(cmd_word);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cur       <= '0;
      operation <= '0;
      in_data   <= '0;
      err       <= 1'b0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          operation <= '0;
          if (!empty) begin
            cur <= head;
            case (head.opcode)
              OP_MM: begin
                state     <= S_MM_RUN;
                operation <= head;
                cnt       <= CW'(MM_HOLD - 1);
              end
              OP_WR: begin
                state <= S_WR_RUN;
                cnt   <= CW'(WR_LEN);
              end
              OP_NOP: ;
              default: err <= 1'b1;
            endcase
          end
        end
        S_MM_RUN: begin
          if (cnt == '0) begin
            state     <= S_MM_DRN;
            operation <= '0;
            cnt       <= CW'(MM_DRAIN - 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_MM_DRN: begin
          operation <= '0;
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        S_WR_RUN: begin
          // A cycle without a data word is a bubble: no write, in_data keeps its value.
          if (data_hs) begin
            operation <= cur;
            in_data   <= data_word;
            cnt       <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_GAP;
          end else begin
            operation <= '0;
          end
        end
        S_GAP: begin
          operation <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_op_issuer.sv
// Self-checking bench for op_issuer: vector table, directed corner sequences and a
// randomized run against a queue-based model of the expected operation stream.
module tb_op_issuer;
  localparam int FIFO_DEPTH = 4;
  localparam int MM_HOLD    = 64;
  localparam int MM_DRAIN   = 16;
  localparam int WR_LEN     = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        data_valid = 1'b0;
  logic [31:0] cmd_word = '0;
  logic [31:0] data_word = '0;
  logic        cmd_ready, data_ready, busy, err;
  logic [31:0] operation, in_data;

  int passed = 0;
  int total  = 0;

  op_issuer #(.FIFO_DEPTH(FIFO_DEPTH), .MM_HOLD(MM_HOLD), .MM_DRAIN(MM_DRAIN), .WR_LEN(WR_LEN)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
    .data_valid(data_valid), .data_ready(data_ready), .data_word(data_word),
    .operation(operation), .in_data(in_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete, got %0d/%0d", passed, total);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 600) begin tick(); k++; end
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  // Push one command into an idle issuer and measure what comes out, sampling once per cycle.
  task automatic run_cmd(input logic [31:0] c, input bit gaps,
                         output int first, output int ncmd, output int blen, output int other,
                         output int dmis, output int bub, output int hmis, output bit done);
    bit is_wr, hs;
    int sent;
    is_wr = (c[3:0] == 4'd2);
    first = -1; ncmd = 0; blen = 0; other = 0; dmis = 0; bub = 0; hmis = 0; done = 0; sent = 0;
    cmd_word = c; cmd_valid = 1'b1; data_word = 32'h100; data_valid = 1'b0;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (operation == c && c != 0) begin
        if (first < 0) first = k;
        if (is_wr && in_data !== 32'h100 + ncmd) dmis++;
        ncmd++;
      end else if (operation != 0) other++;
      else if (is_wr && ncmd > 0 && ncmd < WR_LEN) begin
        bub++;
        if (in_data !== 32'h100 + ncmd - 1) hmis++;
      end
      if (busy) blen++; else done = 1;
      data_valid = is_wr && !done && !(gaps && (k % 3 == 2));
      #1;
      hs = data_valid && data_ready;
      tick();
      if (hs) begin sent++; data_word = 32'h100 + sent; end
    end
    data_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] cmd;
    int          first;
    int          ncmd;
    int          blen;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] op;
    int          idx;
    int          seq;
    bit          mm;
  } ev_t;

  initial begin
    vec_t vt[9];
    int first, ncmd, blen, other, dmis, bub, hmis, n, frz, np;
    bit done, hs, full_chk;
    logic [31:0] prev, fexp[6];
    logic [31:0] runs[$];
    int rlen[$];
    int curlen;

    vt[0] = '{32'h00010821, 1, 64, 81, 1'b0};
    vt[1] = '{32'h00000F82, 2, 32, 34, 1'b0};
    vt[2] = '{32'h00000000, -1, 0, 1, 1'b0};
    vt[3] = '{32'h000F4321, 1, 64, 81, 1'b0};
    vt[4] = '{32'h00000005, -1, 0, 1, 1'b1};
    vt[5] = '{32'h00000000, -1, 0, 1, 1'b1};
    vt[6] = '{32'h00010821, 1, 64, 81, 1'b1};
    vt[7] = '{32'h000ABC12, 2, 32, 34, 1'b1};
    vt[8] = '{32'h0000000F, -1, 0, 1, 1'b1};

    // Reset state
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_operation", operation, 32'h0);
      chk("rst_in_data", in_data, 32'h0);
      chk("rst_flags", {busy, err, cmd_ready, data_ready}, 4'b0000);
    end
    reset = 1'b1;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    chk("rel_busy", busy, 1'b0);

    // Vector table: one command at a time from idle
    for (int i = 0; i < 9; i++) begin
      wait_idle($sformatf("v%0d", i));
      run_cmd(vt[i].cmd, 1'b0, first, ncmd, blen, other, dmis, bub, hmis, done);
      chk($sformatf("v%0d_done", i), done, 1'b1);
      chk($sformatf("v%0d_first", i), first, vt[i].first);
      chk($sformatf("v%0d_ncmd", i), ncmd, vt[i].ncmd);
      chk($sformatf("v%0d_busy_len", i), blen, vt[i].blen);
      chk($sformatf("v%0d_other", i), other, 0);
      chk($sformatf("v%0d_in_data", i), dmis, 0);
      chk($sformatf("v%0d_err", i), err, vt[i].err);
    end

    // Serial write with data_valid dropped every third cycle
    wait_idle("gap");
    run_cmd(32'h00000F82, 1'b1, first, ncmd, blen, other, dmis, bub, hmis, done);
    chk("gap_first", first, 2);
    chk("gap_ncmd", ncmd, 32);
    chk("gap_in_data_order", dmis, 0);
    chk("gap_in_data_hold", hmis, 0);
    chk("gap_bubbles_seen", bub > 0, 1'b1);
    chk("gap_busy_len", blen, 50);
    chk("gap_other", other, 0);

    // FIFO full / back-pressure behind a running matmul
    wait_idle("fifo");
    fexp = '{32'h00010821, 32'h00011111, 32'h00022221, 32'h00033331, 32'h00044441, 32'h00055551};
    np = 0; prev = '0; curlen = 0; full_chk = 0;
    cmd_word = fexp[0]; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (prev != 0 && operation != prev) rlen.push_back(curlen);
      if (operation != 0 && operation != prev) runs.push_back(operation);
      if (operation != 0) curlen = (operation == prev) ? curlen + 1 : 1;
      prev = operation;
      if (np == 5 && !busy) break;
      cmd_valid = (k >= 2 && np < 5);
      if (np < 5) cmd_word = fexp[np + 1];
      #1;
      if (np == 4 && !full_chk) begin chk("fifo_full_ready", cmd_ready, 1'b0); full_chk = 1; end
      hs = cmd_valid && cmd_ready;
      if (hs && np == 4) chk("fifo_5th_after_pop", runs.size(), 2);
      tick();
      if (hs) np++;
    end
    cmd_valid = 1'b0;
    chk("fifo_pushed", np, 5);
    chk("fifo_nruns", runs.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fifo_run%0d_op", i), (i < runs.size()) ? runs[i] : 32'hDEAD, fexp[i]);
      chk($sformatf("fifo_run%0d_len", i), (i < rlen.size()) ? rlen[i] : -1, 64);
    end

    // Enable freeze for 10 cycles in the middle of a matmul
    wait_idle("frz");
    cmd_word = 32'h00020831; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0; blen = 0; frz = 0; done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (operation == 32'h00020831 && enable) n++;
      if (!enable) begin
        chk("frz_operation", operation, 32'h00020831);
        chk("frz_ready", {cmd_ready, data_ready}, 2'b00);
      end
      if (busy) blen++; else done = 1;
      if (n == 20 && frz == 0) begin enable = 1'b0; frz = 1; end
      else if (frz >= 1 && frz <= 10) begin frz++; if (frz == 11) enable = 1'b1; end
      tick();
    end
    enable = 1'b1;
    chk("frz_op_cycles", n, 64);
    chk("frz_busy_len", blen, 91);

    // Reset mid-matmul with a second command still queued
    wait_idle("rst2");
    cmd_word = 32'h00010821; cmd_valid = 1'b1;
    tick();
    cmd_word = 32'h00030841;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_rst_operation", operation, 32'h0);
      chk("mid_rst_flags", {busy, err, cmd_ready, data_ready}, 4'b0000);
      chk("mid_rst_in_data", in_data, 32'h0);
    end
    reset = 1'b1;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    chk("post_rst_fifo_empty", {busy, operation}, 33'h0);

    // Randomized run against the stream model
    begin
      ev_t evq[$];
      ev_t e;
      int cidx, wr_ev, dcnt, last_idx, r;
      bit exp_err, prev_en, hs_c, hs_d, have_pend;
      logic [31:0] pend, last_op;
      logic [3:0] opc;
      cidx = 0; wr_ev = 0; dcnt = 0; last_idx = -1; exp_err = 0; prev_en = 1;
      hs_c = 0; hs_d = 0; have_pend = 0; pend = '0; last_op = '0;
      for (int cyc = 0; cyc < 8000; cyc++) begin
        if (hs_c) begin
          if (pend[3:0] == 4'd1)
            for (int s = 0; s < MM_HOLD; s++) evq.push_back('{pend, cidx, s, 1'b1});
          else if (pend[3:0] == 4'd2)
            for (int s = 0; s < WR_LEN; s++) evq.push_back('{pend, cidx, s, 1'b0});
          else if (pend[3:0] >= 4'd3) exp_err = 1;
          cidx++;
          have_pend = 0;
        end
        if (hs_d) dcnt++;
        if (prev_en && operation != 0) begin
          if (evq.size() == 0) chk("rnd_unexpected_op", operation, 32'h0);
          else begin
            e = evq.pop_front();
            chk("rnd_op", operation, e.op);
            if (!e.mm) begin chk("rnd_in_data", in_data, 32'h50000000 + wr_ev); wr_ev++; end
            if (last_op != 0 && e.idx != last_idx) chk("rnd_separation", last_op, 32'h0);
            if (e.mm && e.seq > 0) chk("rnd_mm_contig", last_op, e.op);
            last_idx = e.idx;
          end
        end
        last_op = operation;
        if (cidx >= 40 && !have_pend && !busy && evq.size() == 0) break;
        if (!have_pend && cidx < 40 && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 9);
          if (r < 4) opc = 4'd1;
          else if (r < 7) opc = 4'd2;
          else if (r == 7) opc = 4'd0;
          else opc = 4'($urandom_range(3, 15));
          pend = {12'h0, 16'($urandom), opc};
          have_pend = 1;
        end
        cmd_valid  = have_pend;
        cmd_word   = pend;
        data_valid = ($urandom_range(0, 9) < 7);
        data_word  = 32'h50000000 + dcnt;
        enable     = ($urandom_range(0, 19) != 0);
        #1;
        hs_c = cmd_valid && cmd_ready;
        hs_d = data_valid && data_ready;
        prev_en = enable;
        tick();
      end
      cmd_valid = 1'b0; data_valid = 1'b0; enable = 1'b1;
      chk("rnd_all_cmds", cidx, 40);
      chk("rnd_drained", evq.size(), 0);
      chk("rnd_busy", busy, 1'b0);
      chk("rnd_err", err, exp_err);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
